// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad front end: drives columns one at a time, synchronizes the rows,
// debounces press and release, and emits a single-cycle pulse with the key code.
module keypad_scan_debounce #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_pulse,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       multi_key
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} stateT;

  stateT         state, stateNext;
  logic [3:0]    rowMeta, rowS, capRow;
  logic [1:0]    colIdx, rowIdx;
  logic [DW-1:0] dwellCnt;
  logic [BW-1:0] dbCnt, relCnt;
  logic [2:0]    lowCount;
  logic          dwellDone, singleLow, multiLow, rowMatch, dbDone, rowsIdle, relDone;

  function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    keyMap = 4'h1;
      4'h1:    keyMap = 4'h2;
      4'h2:    keyMap = 4'h3;
      4'h3:    keyMap = 4'hA;
      4'h4:    keyMap = 4'h4;
      4'h5:    keyMap = 4'h5;
      4'h6:    keyMap = 4'h6;
      4'h7:    keyMap = 4'hB;
      4'h8:    keyMap = 4'h7;
      4'h9:    keyMap = 4'h8;
      4'hA:    keyMap = 4'h9;
      4'hB:    keyMap = 4'hC;
      4'hC:    keyMap = 4'hE;
      4'hD:    keyMap = 4'h0;
      4'hE:    keyMap = 4'hF;
      default: keyMap = 4'hD;
    endcase
  endfunction

  // Rows come straight from the mechanical keypad, so they get two flops before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowMeta <= 4'hF;
      rowS    <= 4'hF;
    end else begin
      rowMeta <= row;
      rowS    <= rowMeta;
    end
  end

  assign lowCount  = {2'b00, ~rowS[0]} + {2'b00, ~rowS[1]} + {2'b00, ~rowS[2]} + {2'b00, ~rowS[3]};
  assign dwellDone = (dwellCnt == DWELL_LAST);
  assign singleLow = (lowCount == 3'd1);
  assign multiLow  = (lowCount >= 3'd2);
  assign rowMatch  = (rowS == capRow);
  assign dbDone    = (dbCnt == DB_LAST);
  assign rowsIdle  = (rowS == 4'hF);
  assign relDone   = (relCnt == DB_LAST);

  always_comb begin
    rowIdx = 2'd0;
    case (capRow)
      4'b1101: rowIdx = 2'd1;
      4'b1011: rowIdx = 2'd2;
      4'b0111: rowIdx = 2'd3;
      default: rowIdx = 2'd0;
    endcase
  end

  always_comb begin
    col         = 4'b1111;
    col[colIdx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      SCAN:     if (dwellDone && singleLow) stateNext = DEBOUNCE;
      DEBOUNCE: if (!rowMatch) stateNext = SCAN;
                else if (dbDone) stateNext = HELD;
      HELD:     if (rowsIdle && relDone) stateNext = SCAN;
      default:  stateNext = SCAN;
    endcase
  end

  // The column stays frozen through DEBOUNCE and HELD so the captured row pattern stays meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      colIdx    <= 2'd0;
      dwellCnt  <= '0;
      dbCnt     <= '0;
      relCnt    <= '0;
      capRow    <= 4'hF;
      key_pulse <= 1'b0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      multi_key <= 1'b0;
      case (state)
        SCAN: begin
          if (dwellDone) begin
            dwellCnt <= '0;
            if (singleLow) begin
              capRow <= rowS;
              dbCnt  <= '0;
            end else begin
              colIdx    <= colIdx + 2'd1;
              multi_key <= multiLow;
            end
          end else begin
            dwellCnt <= dwellCnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!rowMatch) begin
            colIdx   <= colIdx + 2'd1;
            dwellCnt <= '0;
          end else if (dbDone) begin
            key_pulse <= 1'b1;
            key_code  <= keyMap(rowIdx, colIdx);
            key_valid <= 1'b1;
            relCnt    <= '0;
          end else begin
            dbCnt <= dbCnt + 1'b1;
          end
        end
        HELD: begin
          if (!rowsIdle) begin
            relCnt <= '0;
          end else if (relDone) begin
            key_valid <= 1'b0;
            colIdx    <= colIdx + 2'd1;
            dwellCnt  <= '0;
          end else begin
            relCnt <= relCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad model drives the rows from the column drive,
// expected key codes go into a queue and are matched against observed key pulses.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row, col, key_code;
  logic       key_pulse, key_valid, multi_key;

  logic [15:0] pressMask = 16'h0;
  logic        forceEn   = 1'b0;
  logic [3:0]  forceRow  = 4'hF;
  logic [3:0]  keyRows;

  int total = 0;
  int bad   = 0;

  logic [3:0] expQ[$];
  logic [3:0] gotQ[$];
  int gotIdx      = 0;
  int pulseCount  = 0;
  int pulseDouble = 0;
  int multiCount  = 0;
  int multiDouble = 0;
  bit prevPulse   = 1'b0;
  bit prevMulti   = 1'b0;

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_pulse(key_pulse),
    .key_code(key_code), .key_valid(key_valid), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column, so a row reads low only while that column is driven.
  always_comb begin
    keyRows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressMask[r*4+c] && !col[c]) keyRows[r] = 1'b0;
  end
  assign row = forceEn ? forceRow : keyRows;

  always @(negedge clk) begin
    if (key_pulse === 1'b1) begin
      gotQ.push_back(key_code);
      pulseCount++;
      if (prevPulse) pulseDouble++;
    end
    if (multi_key === 1'b1) begin
      multiCount++;
      if (prevMulti) multiDouble++;
    end
    prevPulse = (key_pulse === 1'b1);
    prevMulti = (multi_key === 1'b1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitPulse(input int maxTicks, output bit seen);
    int n = 0;
    while (gotIdx >= gotQ.size() && n < maxTicks) begin
      tick();
      n++;
    end
    seen = (gotIdx < gotQ.size());
  endtask

  task automatic waitValidLow(input int maxTicks, output bit seen);
    int n = 0;
    while (key_valid !== 1'b0 && n < maxTicks) begin
      tick();
      n++;
    end
    seen = (key_valid === 1'b0);
  endtask

  task automatic waitColStart(input logic [3:0] target, output bit found);
    int n = 0;
    while (col === target && n < 40) begin tick(); n++; end
    while (col !== target && n < 40) begin tick(); n++; end
    found = (col === target);
  endtask

  task automatic test_reset();
    logic [3:0] expCol;
    reset = 1'b1;
    repeat (3) tick();
    total++; if (col !== 4'b1110)  begin bad++; $display("[TB] FAIL reset_col got=%b want=1110", col); end
    total++; if (key_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulse got=%b want=0", key_pulse); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", key_valid); end
    total++; if (multi_key !== 1'b0) begin bad++; $display("[TB] FAIL reset_multi got=%b want=0", multi_key); end
    total++; if (key_code !== 4'h0)  begin bad++; $display("[TB] FAIL reset_code got=%h want=0", key_code); end
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expCol = 4'b1111;
      expCol[k/4] = 1'b0;
      total++;
      if (col !== expCol) begin bad++; $display("[TB] FAIL scan_col cycle=%0d got=%b want=%b", k, col, expCol); end
      tick();
    end
  endtask

  task automatic test_press_five();
    bit seen;
    int startPulses = pulseCount;
    int frozenErr = 0;
    logic [3:0] expCode, gotCode;
    pressMask = 16'h0020;
    expQ.push_back(4'h5);
    waitPulse(60, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL key5_pulse got=none want=pulse"); void'(expQ.pop_front()); end
    else begin
      expCode = expQ.pop_front(); gotCode = gotQ[gotIdx]; gotIdx++;
      total++; if (gotCode !== expCode) begin bad++; $display("[TB] FAIL key5_code got=%h want=%h", gotCode, expCode); end
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (col !== 4'b1101 || key_valid !== 1'b1) frozenErr++;
    end
    total++; if (frozenErr !== 0) begin bad++; $display("[TB] FAIL key5_held bad_cycles got=%0d want=0", frozenErr); end
    pressMask = 16'h0;
    repeat (9) tick();
    total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL key5_valid_before_release got=%b want=1", key_valid); end
    tick();
    total++; if (key_valid !== 1'b0) begin bad++; $display("[TB] FAIL key5_valid_after_release got=%b want=0", key_valid); end
    total++; if (pulseCount - startPulses !== 1 || pulseDouble !== 0) begin
      bad++; $display("[TB] FAIL key5_pulse_count got=%0d (double=%0d) want=1", pulseCount - startPulses, pulseDouble);
    end
  endtask

  task automatic test_bounce();
    bit found;
    int startPulses = pulseCount;
    int validErr = 0;
    waitColStart(4'b1110, found);
    total++; if (!found) begin bad++; $display("[TB] FAIL bounce_align got=%b want=1110", col); end
    forceRow = 4'b1101;
    forceEn  = 1'b1;
    repeat (5) tick();
    forceEn = 1'b0;
    repeat (2) tick();
    total++; if (col !== 4'b1110) begin bad++; $display("[TB] FAIL bounce_frozen_col got=%b want=1110", col); end
    tick();
    total++; if (col !== 4'b1101) begin bad++; $display("[TB] FAIL bounce_resume_col got=%b want=1101", col); end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (key_valid !== 1'b0) validErr++;
    end
    total++; if (validErr !== 0 || pulseCount !== startPulses) begin
      bad++; $display("[TB] FAIL bounce_no_press got=valid_cycles %0d pulses %0d want=0 0", validErr, pulseCount - startPulses);
    end
  endtask

  task automatic test_key_sequence();
    int bitIdx[3] = '{14, 12, 15};
    logic [3:0] codes[3] = '{4'hF, 4'hE, 4'hD};
    int startPulses = pulseCount;
    bit seen;
    logic [3:0] expCode, gotCode;
    for (int k = 0; k < 3; k++) begin
      pressMask = 16'h0;
      pressMask[bitIdx[k]] = 1'b1;
      expQ.push_back(codes[k]);
      waitPulse(80, seen);
      total++;
      if (!seen) begin bad++; $display("[TB] FAIL seq%0d_pulse got=none want=pulse", k); void'(expQ.pop_front()); end
      else begin
        expCode = expQ.pop_front(); gotCode = gotQ[gotIdx]; gotIdx++;
        total++; if (gotCode !== expCode) begin bad++; $display("[TB] FAIL seq%0d_code got=%h want=%h", k, gotCode, expCode); end
      end
      repeat (12) tick();
      pressMask = 16'h0;
      waitValidLow(40, seen);
      total++; if (!seen) begin bad++; $display("[TB] FAIL seq%0d_release got=valid %b want=0", k, key_valid); end
      repeat (4) tick();
    end
    total++; if (pulseCount - startPulses !== 3 || pulseDouble !== 0) begin
      bad++; $display("[TB] FAIL seq_pulse_count got=%0d (double=%0d) want=3", pulseCount - startPulses, pulseDouble);
    end
  endtask

  task automatic test_multi_key();
    int startMulti = multiCount;
    int startPulses = pulseCount;
    int validErr = 0;
    pressMask = 16'h0404;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (key_valid !== 1'b0) validErr++;
    end
    pressMask = 16'h0;
    total++; if (multiCount - startMulti < 2 || multiCount - startMulti > 3) begin
      bad++; $display("[TB] FAIL multi_count got=%0d want=2..3", multiCount - startMulti);
    end
    total++; if (multiDouble !== 0) begin bad++; $display("[TB] FAIL multi_width got=%0d wide pulses want=0", multiDouble); end
    total++; if (validErr !== 0 || pulseCount !== startPulses) begin
      bad++; $display("[TB] FAIL multi_no_press got=valid_cycles %0d pulses %0d want=0 0", validErr, pulseCount - startPulses);
    end
    repeat (8) tick();
  endtask

  task automatic test_reset_midflight();
    bit found, seen;
    int startPulses = pulseCount;
    logic [3:0] expCode, gotCode;
    waitColStart(4'b1110, found);
    total++; if (!found) begin bad++; $display("[TB] FAIL rst_align got=%b want=1110", col); end
    forceRow = 4'b1110;
    forceEn  = 1'b1;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    total++; if (col !== 4'b1110 || key_valid !== 1'b0 || key_pulse !== 1'b0 || multi_key !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_debounce_outputs got=col %b valid %b pulse %b multi %b want=1110 0 0 0", col, key_valid, key_pulse, multi_key);
    end
    total++; if (key_code !== 4'h0) begin bad++; $display("[TB] FAIL rst_debounce_code got=%h want=0", key_code); end
    reset = 1'b0;
    expQ.push_back(4'h1);
    waitPulse(60, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL rst_first_pulse got=none want=pulse"); void'(expQ.pop_front()); end
    else begin
      expCode = expQ.pop_front(); gotCode = gotQ[gotIdx]; gotIdx++;
      total++; if (gotCode !== expCode) begin bad++; $display("[TB] FAIL rst_first_code got=%h want=%h", gotCode, expCode); end
    end
    repeat (3) tick();
    total++; if (key_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_held_valid got=%b want=1", key_valid); end
    reset = 1'b1;
    tick();
    total++; if (key_valid !== 1'b0 || key_code !== 4'h0 || col !== 4'b1110 || key_pulse !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_held_outputs got=valid %b code %h col %b pulse %b want=0 0 1110 0", key_valid, key_code, col, key_pulse);
    end
    reset = 1'b0;
    expQ.push_back(4'h1);
    waitPulse(60, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL rst_fresh_pulse got=none want=pulse"); void'(expQ.pop_front()); end
    else begin
      expCode = expQ.pop_front(); gotCode = gotQ[gotIdx]; gotIdx++;
      total++; if (gotCode !== expCode) begin bad++; $display("[TB] FAIL rst_fresh_code got=%h want=%h", gotCode, expCode); end
    end
    forceEn = 1'b0;
    waitValidLow(40, seen);
    total++; if (!seen) begin bad++; $display("[TB] FAIL rst_release got=valid %b want=0", key_valid); end
    total++; if (pulseCount - startPulses !== 2) begin
      bad++; $display("[TB] FAIL rst_pulse_count got=%0d want=2", pulseCount - startPulses);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_press_five();
    test_bounce();
    test_key_sequence();
    test_multi_key();
    test_reset_midflight();
    repeat (4) tick();
    total++; if (expQ.size() !== 0 || gotIdx !== gotQ.size()) begin
      bad++; $display("[TB] FAIL scoreboard_drain got=pending %0d unmatched %0d want=0 0", expQ.size(), gotQ.size() - gotIdx);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
